// File: rtl/cassette_rec.sv
// cassette_rec: MC-10 cassette FSK bit/byte recovery with a one-entry output buffer.
// Define CASSETTE_REC_FILTER_EN to add a 3-tap majority filter ahead of edge detection.
module cassette_rec #(
  parameter int THRESH_US  = 625,
  parameter int MIN_US     = 200,
  parameter int TIMEOUT_US = 1023
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_us,
  input  logic        arm,
  input  logic        clear,
  input  logic        cout,
  output logic [7:0]  byte_data,
  output logic [15:0] byte_addr,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        overflow,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HUNT   = 2'b01,
    LOCKED = 2'b10
  } st_t;

  localparam logic [9:0] THR_P = 10'(THRESH_US);
  localparam logic [9:0] MIN_P = 10'(MIN_US);
  localparam logic [9:0] TMO_P = 10'(TIMEOUT_US);

  st_t        st_q, st_d;
  logic       sync1, sync2, sig, sig_q;
  logic       rise, valid_edge, bit_v, tmo;
  logic [9:0] period_q, period_d;
  logic [7:0] sr_q, sr_d, sh;
  logic [2:0] cnt_q, cnt_d;
  logic       emit, full_q;
  logic       accept, full_eff, load, drop;

`ifdef CASSETTE_REC_FILTER_EN
  logic [2:0] taps;

  always_ff @(posedge clk_sys) begin
    if (reset) taps <= '0;
    else if (ce_us) taps <= {taps[1:0], sync2};
  end

  assign sig = (taps[0] & taps[1]) |
               (taps[1] & taps[2]) |
               (taps[0] & taps[2]);
`else
  assign sig = sync2;
`endif

  assign rise       = sig & ~sig_q;
  assign valid_edge = rise & (period_q >= MIN_P);
  assign bit_v      = period_q < THR_P;
  assign tmo        = (st_q != IDLE) & (period_q >= TMO_P);
  assign state      = st_q;

  always_comb begin
    period_d = period_q;
    if (valid_edge) period_d = '0;
    else if (ce_us && period_q != 10'h3FF)
      period_d = period_q + 10'd1;
  end

  always_comb begin
    st_d  = st_q;
    sr_d  = sr_q;
    cnt_d = cnt_q;
    emit  = 1'b0;
    sh    = {bit_v, sr_q[7:1]};
    if (!arm || tmo) begin
      st_d  = IDLE;
      sr_d  = '0;
      cnt_d = '0;
    end else if (valid_edge) begin
      unique case (st_q)
        IDLE: st_d = HUNT;
        HUNT: begin
          sr_d = sh;
          if (cnt_q == 3'd7 && sh == 8'h55) begin
            emit  = 1'b1;
            cnt_d = '0;
            st_d  = LOCKED;
          end else if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        LOCKED: begin
          sr_d  = sh;
          cnt_d = cnt_q + 3'd1;
          // 3-bit counter wraps to 0 on the 8th bit
          if (cnt_q == 3'd7) emit = 1'b1;
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // clear blocks acceptance so a pending byte re-presents at address 0
  assign accept   = byte_valid & byte_ready & ~clear;
  assign full_eff = full_q | (accept & (byte_addr == 16'hFFFF));
  assign load     = emit & ~full_eff & (~byte_valid | accept);
  assign drop     = emit & ~load;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sig_q      <= 1'b0;
      period_q   <= '0;
      st_q       <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_addr  <= '0;
      overflow   <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      sync1    <= cout;
      sync2    <= sync1;
      sig_q    <= sig;
      period_q <= period_d;
      st_q     <= st_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      byte_valid <= load | (byte_valid & ~accept);
      if (load) byte_data <= sh;
      if (clear) begin
        byte_addr <= '0;
        overflow  <= 1'b0;
        full_q    <= 1'b0;
      end else begin
        if (accept && byte_addr != 16'hFFFF)
          byte_addr <= byte_addr + 16'd1;
        full_q <= full_eff;
        if (drop) overflow <= 1'b1;
      end
    end
  end

endmodule
